// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle for alu_exec_unit.
// The master side presents operations and consumes results; the slave side is the execute stage.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAG_W-1:0] rd_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic [TAG_W-1:0] rd_out;

    modport master (
        output in_valid, alu_control, src_a, src_b, rd_in, out_ready,
        input  in_ready, out_valid, alu_result, zero, rd_out
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, rd_in, out_ready,
        output in_ready, out_valid, alu_result, zero, rd_out
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready on both sides and a one-entry output slot.
// Define ALU_SHIFT_EN to build the iterative SLL/SRL/SRA shifter on codes 100/110/111.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);

`ifdef ALU_SHIFT_EN
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0
    } state_t;
`endif

    state_t           state;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic [TAG_W-1:0] rd_q;

    logic             slot_free;
    logic             accept;
    logic             drain;
    logic             start_shift;
    logic [WIDTH-1:0] alu_value;

`ifdef ALU_SHIFT_EN
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   count_q;
    logic [1:0]       mode_q;
    logic [TAG_W-1:0] tag_q;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shifted;
`endif

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state == IDLE) && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = out_valid_q && bus.out_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.rd_out     = rd_q;

`ifdef ALU_SHIFT_EN
    assign shamt       = bus.src_b[SHW-1:0];
    assign start_shift = accept && bus.alu_control[2] && (bus.alu_control != 3'b101)
                         && (shamt != '0);

    // One bit per edge; mode is the low two bits of the shift opcode.
    always_comb begin
        shifted = work_q;
        case (mode_q)
            2'b00:   shifted = {work_q[WIDTH-2:0], 1'b0};
            2'b10:   shifted = {1'b0, work_q[WIDTH-1:1]};
            2'b11:   shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shifted = work_q;
        endcase
    end
`else
    assign start_shift = 1'b0;
`endif

    // Single-cycle result; a zero-distance shift passes src_a straight through.
    always_comb begin
        alu_value = '0;
        case (bus.alu_control)
            3'b000:  alu_value = bus.src_a + bus.src_b;
            3'b001:  alu_value = bus.src_a - bus.src_b;
            3'b010:  alu_value = bus.src_a & bus.src_b;
            3'b011:  alu_value = bus.src_a | bus.src_b;
            3'b101:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
`ifdef ALU_SHIFT_EN
            3'b100, 3'b110, 3'b111: alu_value = bus.src_a;
`endif
            default: alu_value = '0;
        endcase
    end

    // A slot write later in this block overrides the drain clear, so drain+accept keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rd_q        <= '0;
`ifdef ALU_SHIFT_EN
            work_q      <= '0;
            count_q     <= '0;
            mode_q      <= '0;
            tag_q       <= '0;
`endif
        end else begin
            if (drain) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_shift) begin
`ifdef ALU_SHIFT_EN
                        work_q  <= bus.src_a;
                        count_q <= shamt;
                        mode_q  <= bus.alu_control[1:0];
                        tag_q   <= bus.rd_in;
                        state   <= SHIFT;
`endif
                    end else if (accept) begin
                        out_valid_q <= 1'b1;
                        result_q    <= alu_value;
                        zero_q      <= (alu_value == '0);
                        rd_q        <= bus.rd_in;
                    end
                end
`ifdef ALU_SHIFT_EN
                SHIFT: begin
                    if (count_q == SHW'(1)) begin
                        if (slot_free) begin
                            out_valid_q <= 1'b1;
                            result_q    <= shifted;
                            zero_q      <= (shifted == '0);
                            rd_q        <= tag_q;
                            count_q     <= '0;
                            state       <= IDLE;
                        end
                    end else begin
                        work_q  <= shifted;
                        count_q <= count_q - SHW'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed handshake cases, then a randomized stream
// checked against a transaction-level model of the output slot and the shifter.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int SHW   = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: one result slot plus at most one shift in flight.
    logic             m_slot_v;
    logic [WIDTH-1:0] m_slot_res;
    logic [TAG_W-1:0] m_slot_rd;
    logic             m_busy;
    int               m_left;
    logic [WIDTH-1:0] m_busy_res;
    logic [TAG_W-1:0] m_busy_rd;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] got,
                               input logic [WIDTH-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] ctrl,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [TAG_W-1:0] rd);
        bus.in_valid    = valid;
        bus.alu_control = ctrl;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.rd_in       = rd;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkSlot(input string tag, input logic v, input logic [WIDTH-1:0] res,
                             input logic [TAG_W-1:0] rd);
        checkOutput({tag, "_valid"}, WIDTH'(bus.out_valid), WIDTH'(v));
        if (v) begin
            checkOutput({tag, "_result"}, bus.alu_result, res);
            checkOutput({tag, "_zero"}, WIDTH'(bus.zero), WIDTH'(res == '0));
            checkOutput({tag, "_rd"}, WIDTH'(bus.rd_out), WIDTH'(rd));
        end
    endtask

    // Counts edges after the accept edge until out_valid rises; in_ready must stay low meanwhile.
    task automatic waitValid(input string tag, input int limit, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < limit) begin
            checkOutput({tag, "_busy_ready"}, WIDTH'(bus.in_ready), '0);
            stepCycle();
            lat++;
        end
    endtask

    function automatic logic is_shift_op(input logic [2:0] c);
`ifdef ALU_SHIFT_EN
        return (c == 3'b100) || (c == 3'b110) || (c == 3'b111);
`else
        return (c == 3'b111) && (c == 3'b000);
`endif
    endfunction

    function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
`ifdef ALU_SHIFT_EN
            3'b100:  return a << sh;
            3'b110:  return a >> sh;
            3'b111:  return WIDTH'($signed(a) >>> sh);
`endif
            default: return '0;
        endcase
    endfunction

    task automatic modelEdge();
        logic             exp_ready;
        logic             slot_free;
        logic [WIDTH-1:0] res;
        exp_ready = !m_busy && (!m_slot_v || bus.out_ready);
        checkOutput("rnd_in_ready", WIDTH'(bus.in_ready), WIDTH'(exp_ready));
        slot_free = !m_slot_v || bus.out_ready;
        if (m_slot_v && bus.out_ready) m_slot_v = 1'b0;
        if (m_busy) begin
            if (m_left > 1) begin
                m_left--;
            end else if (slot_free) begin
                m_slot_v   = 1'b1;
                m_slot_res = m_busy_res;
                m_slot_rd  = m_busy_rd;
                m_busy     = 1'b0;
            end
        end
        if (bus.in_valid && exp_ready) begin
            res = ref_alu(bus.alu_control, bus.src_a, bus.src_b);
            if (is_shift_op(bus.alu_control) && bus.src_b[SHW-1:0] != '0) begin
                m_busy     = 1'b1;
                m_left     = int'(bus.src_b[SHW-1:0]);
                m_busy_res = res;
                m_busy_rd  = bus.rd_in;
            end else begin
                m_slot_v   = 1'b1;
                m_slot_res = res;
                m_slot_rd  = bus.rd_in;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        logic [2:0]       c;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", WIDTH'(bus.out_valid), '0);
        checkOutput("reset_result", bus.alu_result, '0);
        checkOutput("reset_zero", WIDTH'(bus.zero), '0);
        checkOutput("reset_rd", WIDTH'(bus.rd_out), '0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));

        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 3'b000, 32'd7, 32'd5, 5'd3);
        stepCycle(); checkSlot("add", 1'b1, 32'd12, 5'd3);
        applyStimulus(1'b1, 3'b001, 32'd5, 32'd5, 5'd4);
        stepCycle(); checkSlot("sub_zero", 1'b1, 32'd0, 5'd4);
        applyStimulus(1'b1, 3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd5);
        stepCycle(); checkSlot("and", 1'b1, 32'h00F0_1200, 5'd5);
        applyStimulus(1'b1, 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd6);
        stepCycle(); checkSlot("or", 1'b1, 32'hFFF0_FF34, 5'd6);
        applyStimulus(1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd7);
        stepCycle(); checkSlot("slt_neg", 1'b1, 32'd1, 5'd7);
        applyStimulus(1'b1, 3'b001, 32'd0, 32'd1, 5'd8);
        stepCycle(); checkSlot("sub_wrap", 1'b1, 32'hFFFF_FFFF, 5'd8);
        applyStimulus(1'b1, 3'b101, 32'h8000_0000, 32'd1, 5'd9);
        stepCycle(); checkSlot("slt_min", 1'b1, 32'd1, 5'd9);
        applyStimulus(1'b1, 3'b101, 32'd1, 32'h8000_0000, 5'd10);
        stepCycle(); checkSlot("slt_min_rev", 1'b1, 32'd0, 5'd10);

        // Back-pressure: result holds, in_ready drops, then drain and accept on one edge.
        applyStimulus(1'b1, 3'b000, 32'd1, 32'd1, 5'd11);
        stepCycle(); checkSlot("bp_first", 1'b1, 32'd2, 5'd11);
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 3'b000, 32'd10, 32'd20, 5'd12);
        #1;
        checkOutput("bp_in_ready_low", WIDTH'(bus.in_ready), '0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkSlot("bp_hold", 1'b1, 32'd2, 5'd11);
            checkOutput("bp_hold_ready", WIDTH'(bus.in_ready), '0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", WIDTH'(bus.in_ready), WIDTH'(1));
        stepCycle(); checkSlot("bp_drain_accept", 1'b1, 32'd30, 5'd12);
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        stepCycle(); checkOutput("drain_clear", WIDTH'(bus.out_valid), '0);

`ifdef ALU_SHIFT_EN
        applyStimulus(1'b1, 3'b111, 32'h8000_0000, 32'd4, 5'd13);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        waitValid("sra", 64, lat);
        checkOutput("sra_latency", WIDTH'(lat), WIDTH'(4));
        checkSlot("sra", 1'b1, 32'hF800_0000, 5'd13);

        applyStimulus(1'b1, 3'b100, 32'h0000_1234, 32'h0000_0020, 5'd14);
        stepCycle(); checkSlot("sll_zero_amount", 1'b1, 32'h0000_1234, 5'd14);

        applyStimulus(1'b1, 3'b110, 32'hFFFF_FFFF, 32'd31, 5'd15);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        waitValid("srl", 64, lat);
        checkOutput("srl_latency", WIDTH'(lat), WIDTH'(31));
        checkSlot("srl", 1'b1, 32'd1, 5'd15);

        // Reset with five shifts still to go must drop the operation entirely.
        applyStimulus(1'b1, 3'b110, 32'h0000_00FF, 32'd10, 5'd16);
        stepCycle();
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        repeat (5) stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", WIDTH'(bus.out_valid), '0);
        stepCycle();
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", WIDTH'(bus.in_ready), WIDTH'(1));
        repeat (12) stepCycle();
        checkOutput("abort_no_output", WIDTH'(bus.out_valid), '0);
`else
        for (int i = 0; i < 3; i++) begin
            c = (i == 0) ? 3'b100 : (i == 1) ? 3'b110 : 3'b111;
            applyStimulus(1'b1, c, 32'hDEAD_BEEF, 32'd3, 5'(17 + i));
            stepCycle(); checkSlot("no_shift", 1'b1, 32'd0, 5'(17 + i));
        end
`endif

        // Randomized stream against the model, starting from a clean reset.
        rst = 1'b1;
        applyStimulus(1'b0, 3'b000, '0, '0, '0);
        stepCycle();
        rst = 1'b0;
        m_slot_v = 1'b0; m_slot_res = '0; m_slot_rd = '0;
        m_busy = 1'b0; m_left = 0; m_busy_res = '0; m_busy_rd = '0;
        for (int n = 0; n < 800; n++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (is_shift_op(c) && $urandom_range(0, 3) != 0) b = WIDTH'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = a;
            applyStimulus($urandom_range(0, 2) != 0, c, a, b, 5'($urandom_range(0, 31)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            modelEdge();
            stepCycle();
            checkSlot("rnd", m_slot_v, m_slot_res, m_slot_rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered execute stage that consumes the 3-bit ALU control code from the ALU decoder along with two operands, and produces a result, a zero flag and a destination tag. The core sits between decode and writeback/branch logic. A valid/ready handshake on both sides lets downstream back-pressure stall the stage. An optional iterative shifter adds multi-cycle SLL/SRL/SRA on the three control codes the decoder leaves unused.

## Interface
- WIDTH, 32, operand and result width; shift amount is src_b[$clog2(WIDTH)-1:0]
- TAG_W, 5, width of the destination-register tag carried alongside the operation
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept this cycle (combinational)
- alu_control  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT; 100 SLL, 110 SRL, 111 SRA (macro only)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B / shift amount
- rd_in  input  TAG_W  destination tag
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result this cycle
- alu_result  output  WIDTH  registered result
- zero  output  1  registered (alu_result == 0)
- rd_out  output  TAG_W  registered tag

## Operation
- States: IDLE, SHIFT. Output slot: out_valid/alu_result/zero/rd_out registers.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Single-cycle ops on accept: result, zero and tag are written to the output slot at that edge, and out_valid is set.
- ADD/SUB: modulo 2^WIDTH, carry/borrow discarded. AND/OR: bitwise. SLT: signed compare, result 1 or 0 zero-extended.
- Code 100/110/111 with macro off: result 0, zero=1, latency 1.
- Unused code 001-style defaults do not apply here; every code maps exactly as listed.
- Output hold: while out_valid && !out_ready, the result, zero and tag hold stable. On out_valid && out_ready with no accept, out_valid clears.
- SHIFT (macro on): on accept with shamt==0, the output is written directly (src_a unchanged). Otherwise, src_a is loaded into a working register, shamt into a counter, the tag is latched, and the state goes to SHIFT.
- In SHIFT, each edge shifts one bit (SLL left; SRL zero-fill; SRA sign-fill) and decrements the counter. The edge that shifts the final bit (count==1) writes the output slot and returns to IDLE.
- If the output slot is still occupied and not draining when count==1, the stage stalls: working register and counter hold.
- in_ready is 0 throughout SHIFT.

## Timing
- Reset values: state IDLE, out_valid 0, alu_result 0, zero 0, rd_out 0, counter 0. in_ready is 1 in the first cycle after reset release.
- Latency is accept edge to out_valid high.
  - Single-cycle ops: 1 cycle.
  - Shifts: max(1, shamt) cycles plus any back-pressure stall.
- Throughput: 1 op/cycle for single-cycle ops when out_ready is held high. Simultaneous drain and accept in the same cycle is legal and leaves out_valid at 1.
- Reset asserted mid-SHIFT aborts the operation; no output is produced for it.
- Inputs are sampled only on the accept edge; they may change freely at any other time.

## Configuration
- ALU_SHIFT_EN defined: SHIFT state, counter and working register are built; codes 100/110/111 perform SLL/SRL/SRA.
- ALU_SHIFT_EN undefined: no SHIFT state; the FSM reduces to IDLE only; codes 100/110/111 give result 0 with latency 1.

## Test plan
- Reset, then ADD 7+5, tag 3, out_ready=1. Next cycle: out_valid=1, alu_result=12, zero=0, rd_out=3. Stream SUB 5-5, AND, OR, SLT (-1<1) back-to-back: results 0 (zero=1), correct bitwise values, 1, one per cycle.
- SUB 0-1: result 0xFFFFFFFF. SLT 0x80000000 vs 1: result 1. SLT 1 vs 0x80000000: result 0.
- Back-pressure: out_ready=0 after one result. in_ready drops, the result holds 3 cycles unchanged. out_ready=1 with a new op presented: drain and accept occur in the same cycle.
- ALU_SHIFT_EN: SRA 0x80000000 by 4 → 0xF8000000 out_valid 4 cycles after accept, in_ready=0 meanwhile. SLL by 0 → latency 1. SRL 0xFFFFFFFF by 31 → 1 after 31 cycles.
- Shift completing into a full slot: the shift stalls until out_ready rises, then the result appears the following edge. Reset at count=5 mid-shift: out_valid=0 and in_ready=1 after release.
- Without ALU_SHIFT_EN: code 110 → result 0, zero=1, latency 1.
